// File: rtl/kernel_frame_sequencer_if.sv
// Fetch and result-buffer bus between kernel_frame_sequencer and the pipeline.
// master: the sequencer (drives requests and writes).
// slave: the window fetch unit and the result buffer.
interface kernel_frame_sequencer_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 17
);
    logic [ADDR_W-1:0] fetch_pixel;
    logic              fetch_req;
    logic              fetch_ready;
    logic [DATA_W-1:0] kernel_result;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              wr_ready;

    modport master (
        output fetch_pixel,
        output fetch_req,
        input  fetch_ready,
        input  kernel_result,
        output wr_addr,
        output wr_data,
        output wr_en,
        input  wr_ready
    );

    modport slave (
        input  fetch_pixel,
        input  fetch_req,
        output fetch_ready,
        output kernel_result,
        input  wr_addr,
        input  wr_data,
        input  wr_en,
        output wr_ready
    );
endinterface

// File: rtl/kernel_frame_sequencer.sv
// Frame-level controller for the 3x3 kernel pipeline.
// Raster-scans a WIDTH x HEIGHT frame, requests a window for every interior
// pixel, clamps the kernel result to 8 bits and writes it to the result buffer.
// Border pixels are written as 0.
// Optional build macro KSEQ_BORDER_SKIP_EN: border pixels take no write and
// are stepped over in one ISSUE cycle each.
module kernel_frame_sequencer #(
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned HEIGHT  = 256,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 17,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] mode_in,
    output logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       timeout_err,
    kernel_frame_sequencer_if.master bus
);
    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = $clog2(HEIGHT);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] pix;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        clamped;

    logic abort_take;
    logic interior;
    logic last_pix;
    logic accept;
    logic advance;
    logic load_write;
    logic captured;
    logic timed_out;

    assign interior   = (row != '0) && (row != ROW_LAST) && (col != '0) && (col != COL_LAST);
    assign last_pix   = (row == ROW_LAST) && (col == COL_LAST);
    assign abort_take = abort && (state != S_IDLE);
    assign busy       = (state != S_IDLE);

    assign bus.fetch_pixel = pix;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;

    // Saturate the signed kernel result into 0..255.
    always_comb begin
        clamped = bus.kernel_result[7:0];
        if (bus.kernel_result[DATA_W-1]) begin
            clamped = '0;
        end else if (bus.kernel_result[DATA_W-2:0] > (DATA_W-1)'(255)) begin
            clamped = '1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, strobes and datapath enables; abort overrides everything.
    always_comb begin
        state_nxt     = state;
        bus.fetch_req = 1'b0;
        bus.wr_en     = 1'b0;
        done          = 1'b0;
        accept        = 1'b0;
        advance       = 1'b0;
        load_write    = 1'b0;
        captured      = 1'b0;
        timed_out     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (interior) begin
                    bus.fetch_req = 1'b1;
                    state_nxt     = S_WAIT;
                end else begin
`ifdef KSEQ_BORDER_SKIP_EN
                    advance   = 1'b1;
                    state_nxt = last_pix ? S_DONE : S_ISSUE;
`else
                    load_write = 1'b1;
                    state_nxt  = S_WRITE;
`endif
                end
            end
            S_WAIT: begin
                if (bus.fetch_ready) begin
                    load_write = 1'b1;
                    captured   = 1'b1;
                    state_nxt  = S_WRITE;
                end else if (wait_cnt == CNT_LAST) begin
                    load_write = 1'b1;
                    timed_out  = 1'b1;
                    state_nxt  = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.wr_en = 1'b1;
                if (bus.wr_ready) begin
                    advance   = 1'b1;
                    state_nxt = last_pix ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Strobes are gated in the abort cycle so nothing is issued or written.
        if (abort_take) begin
            state_nxt     = S_IDLE;
            bus.fetch_req = 1'b0;
            bus.wr_en     = 1'b0;
            done          = 1'b0;
            advance       = 1'b0;
            load_write    = 1'b0;
            captured      = 1'b0;
            timed_out     = 1'b0;
        end
    end

    // Raster position: cleared at frame start, stepped after each pixel,
    // and wrapped back to the origin after the last pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            pix <= '0;
        end else if (accept) begin
            row <= '0;
            col <= '0;
            pix <= '0;
        end else if (advance) begin
            if (last_pix) begin
                row <= '0;
                col <= '0;
                pix <= '0;
            end else if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
                pix <= pix + 1'b1;
            end else begin
                col <= col + 1'b1;
                pix <= pix + 1'b1;
            end
        end
    end

    // WAIT cycle counter, restarted on every ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Write payload, frame mode and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            mode        <= 2'b00;
            timeout_err <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            aborted <= abort_take;
            if (accept) begin
                mode        <= mode_in;
                timeout_err <= 1'b0;
            end
            if (load_write) begin
                wr_addr_q <= pix;
                wr_data_q <= captured ? clamped : '0;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_kernel_frame_sequencer.sv
// Self-checking bench for kernel_frame_sequencer (4x4 frame, TIMEOUT 8).
// A frame-level reference model derives the expected fetch order, write
// list and frame length from the per-pixel stimulus plan.
`timescale 1ns/1ps
module tb_kernel_frame_sequencer;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int TO   = 8;
    localparam int AW   = 17;
    localparam int DW   = 17;
    localparam int NPIX = W * H;
    localparam int NEVER = 999;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] mode_in;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       timeout_err;

    kernel_frame_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    kernel_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_in(mode_in),
        .mode(mode), .busy(busy), .done(done), .aborted(aborted),
        .timeout_err(timeout_err), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;

    int n_checks = 0;
    int n_fail   = 0;

    int            dly [NPIX];
    int            stl [NPIX];
    logic [DW-1:0] val [NPIX];

    wr_t exp_wr[$];
    int  exp_fetch[$];
    int  exp_total;
    bit  exp_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp8(input logic [DW-1:0] v);
        int s;
        s = $signed(v);
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic fill_plan(input int d, input int s, input logic [DW-1:0] v);
        for (int p = 0; p < NPIX; p++) begin
            dly[p] = d;
            stl[p] = s;
            val[p] = v;
        end
    endtask

    task automatic random_plan();
        for (int p = 0; p < NPIX; p++) begin
            dly[p] = ($urandom_range(0, 9) >= 8) ? NEVER : int'($urandom_range(0, 5));
            stl[p] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            val[p] = DW'($urandom);
        end
    endtask

    // Frame model: raster order, interior pixels fetched, cycle cost per pixel.
    task automatic build_model();
        exp_wr.delete();
        exp_fetch.delete();
        exp_total = 0;
        exp_to    = 1'b0;
        for (int p = 0; p < NPIX; p++) begin
            int r;
            int c;
            r = p / W;
            c = p % W;
            if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
                exp_fetch.push_back(p);
                if (dly[p] >= TO) begin
                    exp_to = 1'b1;
                    exp_wr.push_back('{p, 0});
                    exp_total += 1 + TO + stl[p] + 1;
                end else begin
                    exp_wr.push_back('{p, clamp8(val[p])});
                    exp_total += 1 + dly[p] + 1 + stl[p] + 1;
                end
            end else begin
`ifdef KSEQ_BORDER_SKIP_EN
                exp_total += 1;
`else
                exp_wr.push_back('{p, 0});
                exp_total += 1 + stl[p] + 1;
`endif
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mode"}, mode, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_aborted"}, aborted, 1'b0);
        chk({tag, "_timeout_err"}, timeout_err, 1'b0);
        chk({tag, "_fetch_req"}, bus.fetch_req, 1'b0);
        chk({tag, "_fetch_pixel"}, bus.fetch_pixel, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 0);
    endtask

    // One frame, cycle 0 is the start cycle. Inputs change at negedge,
    // outputs are sampled 1 ns later. abort_pix < 0 means no abort.
    task automatic run_frame(input logic [1:0] fmode, input int abort_pix,
                             input bit start_abort, input bit noise);
        int rdy_cnt;
        int rdy_pix;
        int stall_left;
        int abort_cyc;
        int limit;
        int n_wr;
        int n_fe;
        int pre_wr;
        int pre_fe;
        int p;
        bit fin;
        bit hold;
        bit exp_busy;
        logic [AW-1:0] hold_addr;
        logic [7:0]    hold_data;
        wr_t w;

        build_model();
        rdy_cnt = -1; rdy_pix = 0; abort_cyc = -1; n_wr = 0; n_fe = 0;
        fin = 1'b0; hold = 1'b0; hold_addr = '0; hold_data = '0;
        pre_wr = 0; pre_fe = 0;
        foreach (exp_wr[i]) if (exp_wr[i].addr < abort_pix) pre_wr++;
        foreach (exp_fetch[i]) if (exp_fetch[i] <= abort_pix) pre_fe++;
        stall_left = (exp_wr.size() > 0) ? stl[exp_wr[0].addr] : 0;
        limit = (abort_pix < 0) ? exp_total + 2 : 400;

        for (int cyc = 0; cyc <= limit && !fin; cyc++) begin
            start   = (cyc == 0) ||
                      (noise && cyc >= 1 && cyc <= exp_total + 1 && $urandom_range(0, 3) == 0);
            abort   = (cyc == 0 && start_abort) || (cyc == abort_cyc);
            mode_in = (cyc == 0) ? fmode : 2'($urandom);
            if (rdy_cnt == 0) begin
                bus.fetch_ready   = 1'b1;
                bus.kernel_result = val[rdy_pix];
                rdy_cnt = -1;
            end else begin
                bus.fetch_ready   = (rdy_cnt < 0) && ($urandom_range(0, 3) == 0);
                bus.kernel_result = DW'($urandom);
                if (rdy_cnt > 0) rdy_cnt--;
            end
            bus.wr_ready = (stall_left == 0);
            #1;

            if (abort_pix < 0) begin
                exp_busy = (cyc >= 1 && cyc <= exp_total + 1);
                chk("done", done, cyc == exp_total + 1);
                chk("aborted", aborted, 1'b0);
                if (cyc == exp_total + 1) chk("timeout_err_end", timeout_err, exp_to);
                if (cyc == exp_total + 2) fin = 1'b1;
            end else begin
                exp_busy = (cyc >= 1 && (abort_cyc < 0 || cyc <= abort_cyc));
                chk("done_abort_frame", done, 1'b0);
                chk("aborted", aborted, abort_cyc >= 0 && cyc == abort_cyc + 1);
                if (abort_cyc >= 0 && cyc == abort_cyc + 2) fin = 1'b1;
            end
            chk("busy", busy, exp_busy);
            if (exp_busy) chk("mode", mode, fmode);
            if (cyc == 1) chk("timeout_err_clr", timeout_err, 1'b0);

            if (bus.fetch_req) begin
                if (exp_fetch.size() == 0) begin
                    chk("fetch_req_unexpected", bus.fetch_req, 1'b0);
                end else begin
                    p = exp_fetch.pop_front();
                    chk("fetch_pixel", bus.fetch_pixel, p);
                    n_fe++;
                    rdy_cnt = dly[p];
                    rdy_pix = p;
                    if (p == abort_pix) abort_cyc = cyc + 1;
                end
            end

            if (hold) begin
                chk("wr_en_hold", bus.wr_en, 1'b1);
                chk("wr_addr_hold", bus.wr_addr, hold_addr);
                chk("wr_data_hold", bus.wr_data, hold_data);
            end
            hold = 1'b0;
            if (bus.wr_en) begin
                if (bus.wr_ready) begin
                    if (exp_wr.size() == 0) begin
                        chk("write_unexpected", bus.wr_en, 1'b0);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", bus.wr_addr, w.addr);
                        chk("wr_data", bus.wr_data, w.data);
                        n_wr++;
                        stall_left = (exp_wr.size() > 0) ? stl[exp_wr[0].addr] : 0;
                    end
                    rdy_cnt = -1;
                end else begin
                    if (stall_left > 0) stall_left--;
                    hold      = 1'b1;
                    hold_addr = bus.wr_addr;
                    hold_data = bus.wr_data;
                end
            end
            @(negedge clk);
        end

        if (abort_pix < 0) begin
            chk("frame_finished", fin, 1'b1);
            chk("writes_left", exp_wr.size(), 0);
            chk("fetches_left", exp_fetch.size(), 0);
        end else begin
            chk("abort_reached", fin, 1'b1);
            chk("abort_writes", n_wr, pre_wr);
            chk("abort_fetches", n_fe, pre_fe);
        end
        start = 1'b0;
        abort = 1'b0;
        bus.fetch_ready = 1'b0;
        bus.wr_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] m;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode_in = 2'b00;
        bus.fetch_ready = 1'b0; bus.kernel_result = '0; bus.wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Mid-frame reset after a timeout has been flagged.
        mode_in = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        chk("midframe_timeout_err", timeout_err, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midframe_rst");
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);

        // Nominal frame: every window ready one cycle after its request.
        fill_plan(0, 0, DW'(100));
        run_frame(2'b01, -1, 1'b0, 1'b0);

        // Clamp boundaries.
        fill_plan(0, 0, DW'(0));
        val[5] = DW'(-5); val[6] = DW'(300); val[9] = DW'(17'h0FF); val[10] = DW'(17'h100);
        run_frame(2'b10, -1, 1'b0, 1'b0);

        // Write back-pressure at pixel 5.
        fill_plan(0, 0, DW'(77));
        stl[5] = 5;
        run_frame(2'b11, -1, 1'b0, 1'b0);

        // Window never ready at pixel 5.
        fill_plan(0, 0, DW'(42));
        dly[5] = NEVER;
        run_frame(2'b00, -1, 1'b0, 1'b0);

        // Abort while waiting on pixel 6.
        fill_plan(0, 0, DW'(9));
        dly[6] = 3;
        run_frame(2'b01, 6, 1'b0, 1'b0);

        // Restart after abort, with abort raised together with start.
        random_plan();
        run_frame(2'b10, -1, 1'b1, 1'b0);

        // Randomised frames with start pulses while busy.
        for (int f = 0; f < 6; f++) begin
            random_plan();
            m = 2'($urandom);
            run_frame(m, -1, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
